// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for a 5-stage RISC-V pipeline.
// Shadows EX/MEM/WB destination info to steer ALU operand muxes and stall/bubble controls.
module fwd_hazard_ctrl #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              flush,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              stall,
   output logic              bubble,
   output logic [CNT_W-1:0]  stall_count
);

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic              rw;
      logic              mr;
   } ex_stage_t;

   // Load flag is only consumed in EX, so later stages carry just the write info.
   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] rd;
      logic              rw;
   } wr_stage_t;

   localparam logic [1:0] SEL_RF  = 2'd0;
   localparam logic [1:0] SEL_WB  = 2'd1;
   localparam logic [1:0] SEL_MEM = 2'd2;

   ex_stage_t ex_q;
   wr_stage_t mem_q;
   wr_stage_t wb_q;

   logic mem_fwd;
   logic wb_fwd;
   logic hz;
   logic ex_accept;

   assign mem_fwd = mem_q.v & mem_q.rw & (mem_q.rd != '0);
   assign wb_fwd  = wb_q.v  & wb_q.rw  & (wb_q.rd  != '0);

   assign hz = ex_q.v & ex_q.mr & (ex_q.rd != '0) & id_valid &
               ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

   assign stall     = hz & ~flush;
   assign bubble    = hz | flush;
   assign ex_accept = id_valid & ~stall & ~flush;

   // Operand selects: the younger producer (MEM) takes precedence over WB.
   always_comb begin
      fwd_a_sel = SEL_RF;
      fwd_b_sel = SEL_RF;
      if (ex_q.v) begin
         if (mem_fwd && (mem_q.rd == ex_q.rs1))
            fwd_a_sel = SEL_MEM;
         else if (wb_fwd && (wb_q.rd == ex_q.rs1))
            fwd_a_sel = SEL_WB;

         if (mem_fwd && (mem_q.rd == ex_q.rs2))
            fwd_b_sel = SEL_MEM;
         else if (wb_fwd && (wb_q.rd == ex_q.rs2))
            fwd_b_sel = SEL_WB;
      end
   end

   // Shadow pipeline: MEM and WB always advance, EX takes a bubble on stall/flush.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q.v   <= ex_accept;
         ex_q.rs1 <= id_rs1;
         ex_q.rs2 <= id_rs2;
         ex_q.rd  <= id_rd;
         ex_q.rw  <= id_reg_write;
         ex_q.mr  <= id_mem_read;
         mem_q.v  <= ex_q.v;
         mem_q.rd <= ex_q.rd;
         mem_q.rw <= ex_q.rw;
         wb_q     <= mem_q;
      end
   end

   // Saturating count of load-use stall cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_count <= '0;
      else if (stall && (stall_count != '1))
         stall_count <= stall_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed scenarios plus random traffic
// compared against an instruction-level pipeline occupancy model.
module tb_fwd_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       id_reg_write, id_mem_read, flush;
   logic [1:0] fwd_a_sel, fwd_b_sel, fwd_a_sel4, fwd_b_sel4;
   logic       stall, bubble, stall4, bubble4;
   logic [15:0] stall_count;
   logic [3:0]  stall_count4;

   always #5 clk = ~clk;

   fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .bubble(bubble),
      .stall_count(stall_count));

   fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
      .fwd_a_sel(fwd_a_sel4), .fwd_b_sel(fwd_b_sel4), .stall(stall4), .bubble(bubble4),
      .stall_count(stall_count4));

   typedef struct {
      bit v;
      int rs1;
      int rs2;
      int rd;
      bit rw;
      bit mr;
   } ins_t;

   // pipe[0] = instruction in EX, pipe[1] = MEM, pipe[2] = WB
   ins_t pipe[3];
   ins_t cur;
   bit   cur_fl;
   bit   e_stall, e_bubble;
   int   cnt;
   int   checks   = 0;
   int   failures = 0;

   bit r_v, r_rw, r_mr, r_fl;
   int r_1, r_2, r_d;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_sel(int rs);
      if (!pipe[0].v) return 0;
      for (int k = 1; k < 3; k++)
         if (pipe[k].v && pipe[k].rw && rs != 0 && pipe[k].rd == rs)
            return (k == 1) ? 2 : 1;
      return 0;
   endfunction

   function automatic int sat(int c, int mx);
      return (c > mx) ? mx : c;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
      cnt = 0;
      e_stall = 0;
   endtask

   // Called just after a falling edge: drive ID, then compare against the model.
   task automatic apply(bit v, int r1, int r2, int rd, bit rw, bit mr, bit fl);
      bit hz;
      id_valid = v; id_rs1 = 5'(r1); id_rs2 = 5'(r2); id_rd = 5'(rd);
      id_reg_write = rw; id_mem_read = mr; flush = fl;
      #1;
      hz = pipe[0].v && pipe[0].mr && pipe[0].rd != 0 && v &&
           (pipe[0].rd == r1 || pipe[0].rd == r2);
      e_stall  = hz && !fl;
      e_bubble = hz || fl;
      chk("fwd_a",  32'(fwd_a_sel),   32'(exp_sel(pipe[0].rs1)));
      chk("fwd_b",  32'(fwd_b_sel),   32'(exp_sel(pipe[0].rs2)));
      chk("stall",  32'(stall),       32'(e_stall));
      chk("bubble", 32'(bubble),      32'(e_bubble));
      chk("count",  32'(stall_count), 32'(sat(cnt, 65535)));
      chk("count4", 32'(stall_count4), 32'(sat(cnt, 15)));
      chk("stall4", 32'(stall4),      32'(e_stall));
      cur = '{v, r1, r2, rd, rw, mr};
      cur_fl = fl;
   endtask

   task automatic adv();
      @(posedge clk);
      if (e_stall) cnt++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = cur;
      pipe[0].v = cur.v && !e_stall && !cur_fl;
      @(negedge clk);
   endtask

   task automatic nop();
      apply(0, 0, 0, 0, 0, 0, 0);
      adv();
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) nop();
   endtask

   initial begin
      reset = 1'b1;
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      id_reg_write = 0; id_mem_read = 0; flush = 0;
      model_reset();
      @(negedge clk);
      #1;
      chk("rst_a", 32'(fwd_a_sel), 0);
      chk("rst_b", 32'(fwd_b_sel), 0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_bubble", 32'(bubble), 0);
      chk("rst_count", 32'(stall_count), 0);
      @(negedge clk);
      reset = 1'b0;

      // add x5; add x6,x5,x7 back-to-back
      apply(1, 1, 2, 5, 1, 0, 0); adv();
      apply(1, 5, 7, 6, 1, 0, 0); adv();
      apply(0, 0, 0, 0, 0, 0, 0);
      chk("s1_a", 32'(fwd_a_sel), 2);
      chk("s1_b", 32'(fwd_b_sel), 0);
      adv();
      drain();

      // add x5; nop; sub x8,x1,x5
      apply(1, 1, 2, 5, 1, 0, 0); adv();
      nop();
      apply(1, 1, 5, 8, 1, 0, 0); adv();
      apply(0, 0, 0, 0, 0, 0, 0);
      chk("s2_a", 32'(fwd_a_sel), 0);
      chk("s2_b", 32'(fwd_b_sel), 1);
      adv();
      drain();

      // lw x5; add x6,x5,x5
      apply(1, 2, 0, 5, 1, 1, 0); adv();
      apply(1, 5, 5, 6, 1, 0, 0);
      chk("s3_stall", 32'(stall), 1);
      chk("s3_bubble", 32'(bubble), 1);
      adv();
      apply(1, 5, 5, 6, 1, 0, 0);
      chk("s3_nostall", 32'(stall), 0);
      adv();
      apply(0, 0, 0, 0, 0, 0, 0);
      chk("s3_a", 32'(fwd_a_sel), 1);
      chk("s3_b", 32'(fwd_b_sel), 1);
      chk("s3_cnt", 32'(stall_count), 1);
      adv();
      drain();

      // x0 is never forwarded and never causes a load-use stall
      apply(1, 1, 2, 0, 1, 0, 0); adv();
      apply(1, 0, 0, 1, 1, 0, 0); adv();
      apply(0, 0, 0, 0, 0, 0, 0);
      chk("s4_a", 32'(fwd_a_sel), 0);
      chk("s4_b", 32'(fwd_b_sel), 0);
      adv();
      drain();
      apply(1, 3, 0, 0, 1, 1, 0); adv();
      apply(1, 0, 0, 4, 1, 0, 0);
      chk("s4_nostall", 32'(stall), 0);
      adv();
      drain();

      // add x5; add x5; or x9,x5,x3 -> MEM wins
      apply(1, 1, 2, 5, 1, 0, 0); adv();
      apply(1, 3, 4, 5, 1, 0, 0); adv();
      apply(1, 5, 3, 9, 1, 0, 0); adv();
      apply(0, 0, 0, 0, 0, 0, 0);
      chk("s5_a", 32'(fwd_a_sel), 2);
      chk("s5_b", 32'(fwd_b_sel), 0);
      adv();
      drain();

      // flush during a load-use hazard
      apply(1, 2, 0, 7, 1, 1, 0); adv();
      apply(1, 7, 0, 8, 1, 0, 1);
      chk("s5f_stall", 32'(stall), 0);
      chk("s5f_bubble", 32'(bubble), 1);
      adv();
      apply(0, 0, 0, 0, 0, 0, 0);
      chk("s5f_cnt", 32'(stall_count), 1);
      adv();
      drain();

      // asynchronous reset in the middle of a stall cycle
      apply(1, 2, 0, 5, 1, 1, 0); adv();
      apply(1, 5, 5, 6, 1, 0, 0);
      chk("s6_pre_stall", 32'(stall), 1);
      reset = 1'b1;
      #1;
      chk("s6_stall", 32'(stall), 0);
      chk("s6_bubble", 32'(bubble), 0);
      chk("s6_a", 32'(fwd_a_sel), 0);
      chk("s6_b", 32'(fwd_b_sel), 0);
      chk("s6_cnt", 32'(stall_count), 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      apply(1, 2, 0, 5, 1, 1, 0); adv();
      apply(1, 5, 5, 6, 1, 0, 0);
      chk("s6_restall", 32'(stall), 1);
      adv();
      apply(1, 5, 5, 6, 1, 0, 0);
      chk("s6_once", 32'(stall), 0);
      adv();
      drain();

      // random traffic; a stalled ID instruction is re-presented like a held IF/ID
      for (int i = 0; i < 400; i++) begin
         if (!e_stall) begin
            r_v  = ($urandom_range(0, 3) != 0);
            r_1  = $urandom_range(0, 7);
            r_2  = $urandom_range(0, 7);
            r_d  = $urandom_range(0, 7);
            r_mr = ($urandom_range(0, 2) == 0);
            r_rw = r_mr ? 1'b1 : ($urandom_range(0, 3) != 0);
         end
         r_fl = ($urandom_range(0, 9) == 0);
         apply(r_v, r_1, r_2, r_d, r_rw, r_mr, r_fl);
         adv();
      end
      drain();

      // saturation of the 4-bit counter after 20 load-use pairs
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         apply(1, 1, 0, 5, 1, 1, 0); adv();
         apply(1, 5, 2, 6, 1, 0, 0); adv();
         apply(1, 5, 2, 6, 1, 0, 0); adv();
      end
      apply(0, 0, 0, 0, 0, 0, 0);
      chk("sat4", 32'(stall_count4), 15);
      chk("sat16", 32'(stall_count), 20);
      adv();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
